uart_boot_host: RTL and testbench
=================================

# uart_boot_host

Host-side initiator for the UART boot protocol: turns a parallel command request into the byte stream the UART-to-SPI boot bridge expects (optional line break, command byte, lengths, payload) and returns the response bytes. Sits between a local controller and a `uart` instance's byte ports. Lets one of our FPGAs program or boot a second board's SPI flash through its boot UART.

## Interface
Parameters:
- `CLK_FREQ`, 12000000, clock frequency in Hz (documentation/derivation only)
- `BREAK_CYCLES`, 12000, cycles `line_break` is held high (must exceed one UART frame)
- `TIMEOUT_CYCLES`, 1200000, max idle cycles between response bytes in RX phase

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command request
- `cmd_ready`  out  1  high only in IDLE
- `cmd_boot`  in  1  1 = boot command, 0 = transfer
- `cmd_break`  in  1  send line break before the command
- `cmd_tx_len`  in  16  payload bytes to send
- `cmd_rx_len`  in  16  response bytes expected
- `wr_valid`, `wr_data[7:0]`  in; `wr_ready`  out  payload stream
- `rd_valid`, `rd_data[7:0]`  out; `rd_ready`  in  response stream
- `uart_tx_valid`, `uart_tx_data[7:0]`  out; `uart_tx_ready`  in  to UART transmitter
- `uart_rx_valid`, `uart_rx_data[7:0]`  in; `uart_rx_ready`  out  from UART receiver
- `line_break`  out  1  forces external TX line low while high
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse, command completed
- `error`  out  1  one-cycle pulse, RX timeout abort

## Operation
- States: IDLE, BREAK, CMD, TXLEN_L, TXLEN_H, RXLEN_L, RXLEN_H, TX_DATA, RX_DATA.
- Accept on `cmd_valid && cmd_ready`; latch boot/break/lengths. Next: BREAK if `cmd_break`, else CMD.
- BREAK: `line_break`=1 for exactly `BREAK_CYCLES` cycles, then CMD.
- CMD: send 0x00 (boot) or 0x01 (transfer). Boot: after handshake -> IDLE with `done`.
- Header: TXLEN_L/H, RXLEN_L/H send low then high byte of each length; each state advances on `uart_tx_valid && uart_tx_ready`.
- After RXLEN_H: TX_DATA if tx_len != 0, else RX_DATA if rx_len != 0, else IDLE with `done`.
- TX_DATA: pass-through `uart_tx_valid = wr_valid`, `uart_tx_data = wr_data`, `wr_ready = uart_tx_ready`; count handshakes; after tx_len-th -> RX_DATA or IDLE+`done`.
- RX_DATA: `rd_valid = uart_rx_valid`, `rd_data = uart_rx_data`, `uart_rx_ready = rd_ready`; count; after rx_len-th -> IDLE+`done`.
- RX timeout: cycle counter clears on every RX handshake and on RX_DATA entry; reaching `TIMEOUT_CYCLES` -> IDLE with `error`, no `done`.
- Outside RX_DATA: `uart_rx_ready`=1, `rd_valid`=0 (stray bytes discarded). Outside TX_DATA: `wr_ready`=0.

## Timing
- Reset values: `cmd_ready`=1, `uart_rx_ready`=1; all other outputs 0; counters 0; state IDLE.
- `rst` mid-operation: IDLE next cycle, no `done`/`error`, `line_break` drops immediately.
- Header bytes registered, `uart_tx_valid` held high with stable data until ready; one byte per cycle max.
- Pass-through paths are combinational (zero latency).
- `done`/`error` asserted the cycle the state returns to IDLE; `cmd_ready` high that same cycle, so back-to-back commands lose no cycles.
- Lengths are unsigned 16-bit; 0xFFFF gives 65535 bytes; counter compares against len-1 without wrap.
- Final-byte handshake and timeout in the same cycle: handshake wins (`done`).

## Structure
- `boot_proto_pkg`: `CMD_BOOT`=8'h00, `CMD_XFER`=8'h01, state enumeration; shared with the bridge side.
- One sub-module, `cycle_timer`: loadable down-counter with expiry flag, used for both BREAK duration and RX timeout.

## Test plan
- Boot, no break -> UART emits exactly 0x00, `done` pulse, no further bytes.
- Break + transfer tx=3 (AA BB CC), rx=0 -> `line_break` high 12000 cycles, then 01 03 00 00 00 AA BB CC, `done`.
- Transfer tx=0, rx=2, responder returns 5A A5 with `rd_ready` toggling -> header 01 00 00 02 00, `rd` sees 5A A5, `done`.
- tx=0, rx=0 -> header only, `done` on RXLEN_H handshake.
- rx=4, responder sends 2 bytes then stops -> `error` exactly `TIMEOUT_CYCLES` after last byte, IDLE, `cmd_ready`=1.
- `rst` asserted in TX_DATA after byte 1 of 5 -> IDLE next cycle, `wr_ready`=0, no `done`; new command accepted normally.

Source files
------------

// File: rtl/boot_proto_pkg.sv
// Shared definitions for the UART boot protocol, used by both the host initiator and the bridge.
package boot_proto_pkg;

  localparam logic [7:0] CMD_BOOT = 8'h00;
  localparam logic [7:0] CMD_XFER = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BREAK,
    ST_CMD,
    ST_TXLEN_L,
    ST_TXLEN_H,
    ST_RXLEN_L,
    ST_RXLEN_H,
    ST_TX_DATA,
    ST_RX_DATA
  } boot_state_e;

  function automatic logic [7:0] cmd_byte(input logic boot);
    return boot ? CMD_BOOT : CMD_XFER;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired is high once the count has reached zero.
module cycle_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/uart_boot_host.sv
// Host-side UART boot initiator: serialises break, command, length header and payload,
// then forwards the response bytes, aborting if the responder goes quiet.
module uart_boot_host
  import boot_proto_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 12000000,
  parameter int unsigned BREAK_CYCLES   = CLK_FREQ / 1000,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_boot,
  input  logic        cmd_break,
  input  logic [15:0] cmd_tx_len,
  input  logic [15:0] cmd_rx_len,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_ready,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_ready,
  output logic        line_break,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned TW = 32;
  localparam logic [TW-1:0] BREAK_LOAD   = TW'(BREAK_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  boot_state_e   state;
  logic          cmd_ready_q, busy_q, done_q, error_q, line_break_q, tx_valid_q;
  logic [7:0]    tx_data_q;
  logic [15:0]   byte_cnt;
  logic          boot_q;
  logic [15:0]   tx_len_q, rx_len_q;
  logic          accept, tx_hs, rx_hs, tx_last, rx_last, enter_rx;
  logic          timer_load, timer_en, timer_expired;
  logic [TW-1:0] timer_val;

  assign accept   = cmd_valid && cmd_ready_q;
  assign tx_hs    = uart_tx_valid && uart_tx_ready;
  assign rx_hs    = (state == ST_RX_DATA) && uart_rx_valid && rd_ready;
  // Lengths are non-zero whenever these are consulted, so len-1 never wraps.
  assign tx_last  = (byte_cnt == tx_len_q - 16'd1);
  assign rx_last  = (byte_cnt == rx_len_q - 16'd1);
  assign enter_rx = (rx_len_q != 16'd0) && tx_hs &&
                    (((state == ST_RXLEN_H) && (tx_len_q == 16'd0)) ||
                     ((state == ST_TX_DATA) && tx_last));

  // One timer serves both the break width and the response idle timeout.
  assign timer_load = (accept && cmd_break) || enter_rx || rx_hs;
  assign timer_val  = (state == ST_IDLE) ? BREAK_LOAD : TIMEOUT_LOAD;
  assign timer_en   = (state == ST_BREAK) || (state == ST_RX_DATA);

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .expired  (timer_expired)
  );

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign line_break    = line_break_q && !rst;
  assign uart_tx_valid = (state == ST_TX_DATA) ? wr_valid : tx_valid_q;
  assign uart_tx_data  = (state == ST_TX_DATA) ? wr_data : tx_data_q;
  assign wr_ready      = (state == ST_TX_DATA) && uart_tx_ready;
  assign rd_valid      = (state == ST_RX_DATA) && uart_rx_valid;
  assign rd_data       = (state == ST_RX_DATA) ? uart_rx_data : 8'h00;
  assign uart_rx_ready = (state == ST_RX_DATA) ? rd_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (accept) begin
      boot_q   <= cmd_boot;
      tx_len_q <= cmd_tx_len;
      rx_len_q <= cmd_rx_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      line_break_q <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      byte_cnt     <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          if (cmd_break) begin
            state        <= ST_BREAK;
            line_break_q <= 1'b1;
          end else begin
            state      <= ST_CMD;
            tx_valid_q <= 1'b1;
            tx_data_q  <= cmd_byte(cmd_boot);
          end
        end
        ST_BREAK: if (timer_expired) begin
          state        <= ST_CMD;
          line_break_q <= 1'b0;
          tx_valid_q   <= 1'b1;
          tx_data_q    <= cmd_byte(boot_q);
        end
        ST_CMD: if (tx_hs) begin
          if (boot_q) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            tx_valid_q  <= 1'b0;
          end else begin
            state     <= ST_TXLEN_L;
            tx_data_q <= tx_len_q[7:0];
          end
        end
        ST_TXLEN_L: if (tx_hs) begin
          state     <= ST_TXLEN_H;
          tx_data_q <= tx_len_q[15:8];
        end
        ST_TXLEN_H: if (tx_hs) begin
          state     <= ST_RXLEN_L;
          tx_data_q <= rx_len_q[7:0];
        end
        ST_RXLEN_L: if (tx_hs) begin
          state     <= ST_RXLEN_H;
          tx_data_q <= rx_len_q[15:8];
        end
        ST_RXLEN_H: if (tx_hs) begin
          tx_valid_q <= 1'b0;
          byte_cnt   <= '0;
          if (tx_len_q != 16'd0) begin
            state <= ST_TX_DATA;
          end else if (rx_len_q != 16'd0) begin
            state <= ST_RX_DATA;
          end else begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        ST_TX_DATA: if (tx_hs) begin
          if (tx_last) begin
            byte_cnt <= '0;
            if (rx_len_q != 16'd0) begin
              state <= ST_RX_DATA;
            end else begin
              state       <= ST_IDLE;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end
          end else begin
            byte_cnt <= byte_cnt + 16'd1;
          end
        end
        // A handshake on the final byte takes priority over a coincident timeout.
        ST_RX_DATA: if (rx_hs) begin
          if (rx_last) begin
            state       <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 16'd1;
          end
        end else if (timer_expired) begin
          state       <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          error_q     <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_host.sv
// Randomised scoreboard bench for uart_boot_host: a byte-level protocol model fills
// expectation queues, independent monitors pop and compare as the DUT produces output.
module tb_uart_boot_host;

  localparam int unsigned CLK_FREQ = 100000;
  localparam int unsigned BRK      = 200;
  localparam int unsigned TMO      = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_boot = 1'b0, cmd_break = 1'b0;
  logic [15:0] cmd_tx_len = '0, cmd_rx_len = '0;
  logic        cmd_ready;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        wr_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready = 1'b0;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready = 1'b0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_ready;
  logic        line_break, busy, done, error;

  uart_boot_host #(
    .CLK_FREQ       (CLK_FREQ),
    .BREAK_CYCLES   (BRK),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_boot      (cmd_boot),
    .cmd_break     (cmd_break),
    .cmd_tx_len    (cmd_tx_len),
    .cmd_rx_len    (cmd_rx_len),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_ready      (rd_ready),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_ready (uart_rx_ready),
    .line_break    (line_break),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wr_src[$];
  logic [7:0] rx_src[$];
  logic [7:0] fixed_pay[$];
  logic [7:0] fixed_rsp[$];
  int         exp_evt[$];   // 1 = done, 2 = error
  bit         exp_brk[$];
  int n_tests = 0, n_fail = 0;
  int evt_cnt = 0;
  int brk_run = 0, brk_len = 0;
  int last_rx_cyc = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string name, input int act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, required nothing (cycle %0d)", name, act, cyc);
  endfunction

  // Monitor
  always @(negedge clk) begin : monitor
    int e;
    bit b;
    if (!rst) begin
      if (uart_tx_valid && uart_tx_ready) begin
        if (exp_tx.size() == 0) unexpected("tx_extra_byte", int'(uart_tx_data));
        else chk("tx_byte", int'(uart_tx_data), int'(exp_tx.pop_front()));
      end
      if (rd_valid && rd_ready) begin
        last_rx_cyc = cyc;
        if (exp_rd.size() == 0) unexpected("rd_extra_byte", int'(rd_data));
        else chk("rd_byte", int'(rd_data), int'(exp_rd.pop_front()));
      end
      if (line_break) begin
        brk_run++;
        chk("tx_quiet_in_break", int'(uart_tx_valid), 0);
      end else if (brk_run != 0) begin
        brk_len = brk_run;
        brk_run = 0;
      end
      if (done || error) begin
        evt_cnt++;
        if (exp_evt.size() == 0) begin
          unexpected("completion_extra", int'({error, done}));
        end else begin
          e = exp_evt.pop_front();
          b = exp_brk.pop_front();
          chk("completion", int'({error, done}), e);
          chk("break_cycles", brk_len, b ? int'(BRK) : 0);
          chk("ready_on_completion", int'({cmd_ready, busy}), 2);
          chk("tx_drained", exp_tx.size(), 0);
          chk("rd_drained", exp_rd.size(), 0);
          // The last byte is taken on the edge after it is seen here; the abort
          // pulse must land TMO edges after that acceptance.
          if (e == 2) chk("timeout_gap", cyc - last_rx_cyc, int'(TMO) + 1);
          brk_len = 0;
        end
      end
    end
  end

  // UART transmitter sink and response consumer back-pressure
  initial begin
    forever begin
      @(posedge clk); #1;
      uart_tx_ready = ($urandom_range(0, 2) != 0);
      rd_ready      = ($urandom_range(0, 2) != 0);
    end
  end

  // Payload source
  initial begin : feeder
    bit hs;
    forever begin
      @(negedge clk);
      hs = wr_valid && wr_ready && !rst;
      @(posedge clk); #1;
      if (hs && wr_src.size() != 0) wr_src.delete(0);
      if (wr_src.size() != 0 && $urandom_range(0, 3) != 0) begin
        wr_valid = 1'b1;
        wr_data  = wr_src[0];
      end else begin
        wr_valid = 1'b0;
        wr_data  = 8'($urandom);
      end
    end
  end

  // Remote bridge: answers only once the whole request has left, sprinkles junk before that
  initial begin : responder
    bit hs, real_b;
    real_b = 1'b0;
    forever begin
      @(negedge clk);
      hs = uart_rx_valid && uart_rx_ready && real_b && !rst;
      @(posedge clk); #1;
      if (hs && rx_src.size() != 0) rx_src.delete(0);
      if (exp_tx.size() == 0 && rx_src.size() != 0 && $urandom_range(0, 1) == 1) begin
        uart_rx_valid = 1'b1;
        uart_rx_data  = rx_src[0];
        real_b        = 1'b1;
      end else if (exp_tx.size() != 0 && $urandom_range(0, 7) == 0) begin
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'($urandom);
        real_b        = 1'b0;
      end else begin
        uart_rx_valid = 1'b0;
        real_b        = 1'b0;
      end
    end
  end

  task automatic start_cmd(input bit boot, input bit brk, input int txl, input int rxl, input int nsend);
    logic [7:0] b;
    bit taken;
    exp_tx.push_back(boot ? 8'h00 : 8'h01);
    if (!boot) begin
      exp_tx.push_back(txl[7:0]);
      exp_tx.push_back(txl[15:8]);
      exp_tx.push_back(rxl[7:0]);
      exp_tx.push_back(rxl[15:8]);
      for (int i = 0; i < txl; i++) begin
        b = (fixed_pay.size() != 0) ? fixed_pay.pop_front() : 8'($urandom);
        exp_tx.push_back(b);
        wr_src.push_back(b);
      end
      for (int i = 0; i < nsend; i++) begin
        b = (fixed_rsp.size() != 0) ? fixed_rsp.pop_front() : 8'($urandom);
        exp_rd.push_back(b);
        rx_src.push_back(b);
      end
    end
    exp_evt.push_back((!boot && nsend < rxl) ? 2 : 1);
    exp_brk.push_back(brk);
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_boot   = boot;
    cmd_break  = brk;
    cmd_tx_len = 16'(txl);
    cmd_rx_len = 16'(rxl);
    taken = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        taken = 1'b1;
        break;
      end
    end
    chk("cmd_accepted", int'(taken), 1);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_boot   = 1'($urandom);
    cmd_break  = 1'($urandom);
    cmd_tx_len = 16'($urandom);
    cmd_rx_len = 16'($urandom);
  endtask

  task automatic flush();
    exp_tx.delete();
    exp_rd.delete();
    wr_src.delete();
    rx_src.delete();
    exp_evt.delete();
    exp_brk.delete();
    brk_run = 0;
    brk_len = 0;
  endtask

  task automatic wait_done();
    int start;
    bit seen;
    start = evt_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk);
      if (evt_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("cmd_completes", int'(seen), 1);
    if (!seen) flush();
  endtask

  // Called just after a rising edge; holds rst across exactly one edge.
  task automatic pulse_rst();
    #2;
    rst = 1'b1;
    flush();
    @(negedge clk);
    chk("line_break_drops_in_rst", int'(line_break), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("state_after_rst", int'({cmd_ready, busy, wr_ready, done, error, line_break}), 6'b100000);
  endtask

  initial begin : stimulus
    bit boot, brk;
    int txl, rxl, ns;

    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        int'({cmd_ready, uart_rx_ready, busy, done, error, line_break, uart_tx_valid, wr_ready, rd_valid}),
        9'b110000000);
    chk("reset_tx_data", int'(uart_tx_data), 0);

    // Boot command, then idle to catch any stray extra byte
    start_cmd(1'b1, 1'b0, 0, 0, 0);
    wait_done();
    repeat (20) @(posedge clk);

    // Break + transfer of AA BB CC
    fixed_pay = '{8'hAA, 8'hBB, 8'hCC};
    start_cmd(1'b0, 1'b1, 3, 0, 0);
    wait_done();

    // Response-only transfer returning 5A A5
    fixed_rsp = '{8'h5A, 8'hA5};
    start_cmd(1'b0, 1'b0, 0, 2, 2);
    wait_done();

    // Header only
    start_cmd(1'b0, 1'b0, 0, 0, 0);
    wait_done();

    // Responder stalls after 2 of 4 bytes
    start_cmd(1'b0, 1'b0, 0, 4, 2);
    wait_done();
    @(negedge clk);
    chk("ready_after_timeout", int'(cmd_ready), 1);

    // Reset during payload, after the first of five bytes
    start_cmd(1'b0, 1'b0, 5, 0, 0);
    for (int i = 0; i < 5000 && exp_tx.size() > 4; i++) @(posedge clk);
    pulse_rst();

    // Reset while the break is being driven
    start_cmd(1'b0, 1'b1, 2, 0, 0);
    repeat (20) @(posedge clk);
    pulse_rst();

    // Normal operation resumes; wide length headers
    start_cmd(1'b0, 1'b0, 2, 1, 1);
    wait_done();
    start_cmd(1'b0, 1'b0, 0, 65535, 1);
    wait_done();
    start_cmd(1'b0, 1'b0, 300, 1, 1);
    wait_done();

    for (int n = 0; n < 30; n++) begin
      boot = ($urandom_range(0, 4) == 0);
      brk  = ($urandom_range(0, 3) == 0);
      txl  = $urandom_range(0, 6);
      rxl  = $urandom_range(0, 6);
      ns   = rxl;
      if (rxl >= 2 && $urandom_range(0, 5) == 0) ns = $urandom_range(1, rxl - 1);
      start_cmd(boot, brk, txl, rxl, ns);
      wait_done();
    end

    repeat (20) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
